mknf_sweep_ctrl: RTL
====================

Name: mknf_sweep_ctrl

Overview:
Sequencer for the switch-level MKNF function cell and its tri-state output buffer. It drives the 4-bit input vector x and the buffer enable en, and waits a programmable settle time per vector. It samples the buffered output f, builds the 16-entry truth table, compares it against the expected function, and finally checks that f is high-Z when en=0. It sits between a test/host controller and the cell and runs one full self-check per start pulse.

Parameters:
SETTLE, 2, clock cycles x/en are held before f is sampled (legal range 1..15)
EXPECT, 16'h55F2, expected truth table, bit k = f for x=k; function is (x3|x2|x0)&(x2|~x1|~x0)&(~x3|~x0)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a sweep; ignored while busy=1
abort  input  1  terminate a running sweep
f_in  input  1  sampled buffered output f of the cell
f_hiz  input  1  high when the f net is undriven (external detector/keeper)
x_out  output  4  input vector to cell (x[3:0])
en_out  output  1  output-buffer enable to cell
busy  output  1  sweep in progress
done  output  1  one-cycle pulse, sweep complete, results valid
pass  output  1  table matched EXPECT and high-Z check passed
table_out  output  16  captured truth table, bit k = f_in sampled at x=k
err_cnt  output  5  number of mismatching entries (0..16)
first_err  output  4  lowest x index that mismatched
err_valid  output  1  first_err is meaningful (at least one mismatch)

Behaviour:
- Reset (async, rst_n=0): state IDLE; x_out=0, en_out=0, busy=0, done=0, pass=0, table_out=0, err_cnt=0, first_err=0, err_valid=0, hiz_err=0, settle counter=0.
- States: IDLE, DRIVE, SAMPLE, HIZ_WAIT, HIZ_SAMPLE, DONE.
- IDLE: en_out=0, busy=0. On start=1: clear table_out, err_cnt, first_err, err_valid, hiz_err. Set x_out=0, en_out=1, load counter=SETTLE-1, go to DRIVE.
- DRIVE: busy=1, en_out=1, x_out stable. Decrement counter; at 0 go to SAMPLE. Duration is SETTLE cycles.
- SAMPLE (1 cycle): table_out[x_out]<=f_in. If f_in!=EXPECT[x_out], increment err_cnt; on the first mismatch also set first_err=x_out and err_valid=1.
  - x_out<15: increment x_out, reload counter, go to DRIVE.
  - x_out==15: x_out<=0, en_out<=0, reload counter, go to HIZ_WAIT. x_out does not wrap back into DRIVE.
- HIZ_WAIT: en_out=0 for SETTLE cycles, then HIZ_SAMPLE.
- HIZ_SAMPLE (1 cycle): hiz_err<=~f_hiz, go to DONE.
- DONE (1 cycle): done=1, busy=1. pass=(err_cnt==0)&&!hiz_err is registered here and held until the next accepted start. Then go to IDLE.
- Latency: done is high in the cycle beginning 17*(SETTLE+1) rising edges after the edge that samples start (51 for SETTLE=2).
- start while busy: ignored, with no effect on counters or results.
- abort: honoured in any state except IDLE and has priority over start and over the normal transition. Next state is IDLE with en_out=0, x_out=0, busy=0. No done pulse; pass=0; partial table/err outputs are retained.
- start and abort asserted together in IDLE: abort has no effect and start is accepted.
- Reset mid-sweep: immediate async return to reset values; en_out drops without waiting for a clock.
- err_cnt saturates naturally at 16 (5-bit) and never wraps.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared include mknf_defs.vh holds:
  - state encodings (3-bit localparams);
  - MKNF_EXPECT_DEFAULT=16'h55F2;
  - the vector count 16.
- No sub-module is required. The settle counter is 4 bits inline; keep the block flat.

Test Plan:
- Ideal cell model (f_in=EXPECT[x_out] when en_out=1, f_hiz=~en_out), SETTLE=2, start pulse -> done at edge 51, pass=1, table_out=16'h55F2, err_cnt=0, err_valid=0.
- Fault at x=3 (f_in forced 1 when x_out==3) -> table_out=16'h55FA, err_cnt=1, first_err=3, err_valid=1, pass=0.
- f_in stuck 0 -> table_out=0, err_cnt=9, first_err=1, pass=0.
- Ideal cell but f_hiz held 0 -> err_cnt=0, pass=0 at done.
- abort asserted in DRIVE with x_out=7 -> next cycle busy=0, en_out=0, x_out=0, no done pulse. A second start mid-sweep is ignored. A fresh start afterwards yields pass=1 at edge 51.
- rst_n low while x_out=10 -> en_out=0 and busy=0 asynchronously before the next clk edge, all outputs at reset values.

Source files
------------

// File: rtl/mknf_sweep_ctrl_pkg.sv
// mknf_sweep_ctrl_pkg
//   Shared definitions for the MKNF cell sweep controller.
//   - state_e             : sequencer state encoding (3-bit)
//   - MKNF_EXPECT_DEFAULT : truth table of (x3|x2|x0)&(x2|~x1|~x0)&(~x3|~x0),
//                           bit k = f for x = k
//   - MKNF_NUM_VEC        : number of input vectors swept (4-bit x)
//   - MKNF_SETTLE_DEFAULT : default settle time in clock cycles
package mknf_sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DRIVE      = 3'd1,
    ST_SAMPLE     = 3'd2,
    ST_HIZ_WAIT   = 3'd3,
    ST_HIZ_SAMPLE = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  localparam logic [15:0] MKNF_EXPECT_DEFAULT = 16'h55F2;
  localparam int unsigned MKNF_NUM_VEC        = 16;
  localparam int unsigned MKNF_SETTLE_DEFAULT = 2;

  localparam logic [3:0]  MKNF_LAST_VEC       = 4'(MKNF_NUM_VEC - 1);

endpackage

// File: rtl/mknf_sweep_ctrl.sv
// mknf_sweep_ctrl
//   Runs one full self-check of the MKNF function cell and its tri-state
//   output buffer per start pulse: drives every x vector with the buffer
//   enabled, samples f after SETTLE cycles, builds the truth table and
//   compares it to EXPECT, then disables the buffer and checks f is high-Z.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle sweep request, ignored while busy
//   abort      in   terminate a running sweep (no done pulse)
//   f_in       in   buffered cell output f
//   f_hiz      in   high when the f net is undriven
//   x_out      out  [3:0] input vector to the cell
//   en_out     out  output-buffer enable to the cell
//   busy       out  sweep in progress
//   done       out  one-cycle pulse, results valid
//   pass       out  table matched and high-Z check passed
//   table_out  out  [15:0] captured truth table, bit k = f at x=k
//   err_cnt    out  [4:0] number of mismatching entries
//   first_err  out  [3:0] lowest mismatching x
//   err_valid  out  first_err is meaningful
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | waiting for start, buffer disabled
// ST_DRIVE     | x/en held, settle counter counting down
// ST_SAMPLE    | capture f for current x, advance or go to high-Z check
// ST_HIZ_WAIT  | buffer disabled, settle counter counting down
// ST_HIZ_SAMPLE| capture high-Z detector, form pass
// ST_DONE      | done pulse, results valid
module mknf_sweep_ctrl
  import mknf_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE = MKNF_SETTLE_DEFAULT,
  parameter logic [15:0] EXPECT = MKNF_EXPECT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  input  logic        f_hiz,
  output logic [3:0]  x_out,
  output logic        en_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] table_out,
  output logic [4:0]  err_cnt,
  output logic [3:0]  first_err,
  output logic        err_valid
);

  // Counter is loaded with SETTLE-1 and the state moves on at terminal
  // count 0, so each DRIVE/HIZ_WAIT phase lasts exactly SETTLE cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_e     state;
  logic [3:0] settle_cnt;
  logic       hiz_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= 4'd0;
      hiz_err    <= 1'b0;
      x_out      <= 4'd0;
      en_out     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      table_out  <= 16'd0;
      err_cnt    <= 5'd0;
      first_err  <= 4'd0;
      err_valid  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        // Partial table and error outputs are kept for debug.
        state      <= ST_IDLE;
        settle_cnt <= 4'd0;
        x_out      <= 4'd0;
        en_out     <= 1'b0;
        busy       <= 1'b0;
        pass       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            busy   <= 1'b0;
            en_out <= 1'b0;
            if (start) begin
              table_out  <= 16'd0;
              err_cnt    <= 5'd0;
              first_err  <= 4'd0;
              err_valid  <= 1'b0;
              hiz_err    <= 1'b0;
              pass       <= 1'b0;
              x_out      <= 4'd0;
              en_out     <= 1'b1;
              busy       <= 1'b1;
              settle_cnt <= SETTLE_LOAD;
              state      <= ST_DRIVE;
            end
          end

          ST_DRIVE: begin
            if (settle_cnt == 4'd0) state <= ST_SAMPLE;
            else                    settle_cnt <= settle_cnt - 4'd1;
          end

          ST_SAMPLE: begin
            table_out[x_out] <= f_in;
            if (f_in != EXPECT[x_out]) begin
              if (err_cnt != 5'd16) err_cnt <= err_cnt + 5'd1;
              if (!err_valid) begin
                first_err <= x_out;
                err_valid <= 1'b1;
              end
            end
            settle_cnt <= SETTLE_LOAD;
            if (x_out == MKNF_LAST_VEC) begin
              x_out  <= 4'd0;
              en_out <= 1'b0;
              state  <= ST_HIZ_WAIT;
            end else begin
              x_out <= x_out + 4'd1;
              state <= ST_DRIVE;
            end
          end

          ST_HIZ_WAIT: begin
            if (settle_cnt == 4'd0) state <= ST_HIZ_SAMPLE;
            else                    settle_cnt <= settle_cnt - 4'd1;
          end

          ST_HIZ_SAMPLE: begin
            // pass is formed here from the live detector so it is valid in
            // the same cycle as the done pulse.
            hiz_err <= ~f_hiz;
            pass    <= (err_cnt == 5'd0) && f_hiz;
            done    <= 1'b1;
            state   <= ST_DONE;
          end

          ST_DONE: begin
            pass  <= pass && !hiz_err;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end

          default: begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            en_out <= 1'b0;
            x_out  <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule
